// File: rtl/gate_seq_pkg.sv
// gate_seq_pkg: shared types and constants for the gate sequencer.
// State encoding, vector count, error counter width, reference truth tables.
package gate_seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0001,
        ST_SETTLE = 4'b0010,
        ST_SAMPLE = 4'b0100,
        ST_DONE   = 4'b1000
    } state_t;

    localparam int N_VEC = 4;
    localparam int ERR_W = 3;

    localparam logic [1:0]       IDX_LAST = 2'(N_VEC - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = ERR_W'(N_VEC);

    // Truth tables indexed by {B,A}
    localparam logic [3:0] TT_XNOR = 4'b1001;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;

    // Saturating mismatch counter step
    function automatic logic [ERR_W-1:0] err_step(
        input logic [ERR_W-1:0] cnt,
        input logic             hit
    );
        if (hit && (cnt < ERR_MAX))
            return cnt + ERR_W'(1);
        return cnt;
    endfunction

endpackage

// File: rtl/gate_seq_timer.sv
// gate_seq_timer: 4-bit settle down-counter.
// Ports: CLK, RST (sync, high), i_load/i_load_val (preset), i_count (decrement), o_expire (count is zero).
module gate_seq_timer (
    input  logic       CLK,
    input  logic       RST,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_count,
    output logic       o_expire
);

    logic [3:0] r_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= 4'd0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_count && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign o_expire = (r_cnt == 4'd0);

endmodule

// File: rtl/gate_seq_ctrl.sv
// gate_seq_ctrl: drives 4 input vectors into a 2-input gate, checks X against TT, reports PASS/ERR_CNT.
// Ports: CLK, RST (sync, high), START, ABORT, X in; A, B, BUSY, DONE, PASS, ERR_CNT out; OBS out with GATE_SEQ_OBS_EN.
module gate_seq_ctrl
    import gate_seq_pkg::*;
#(
    parameter logic [3:0] TT         = TT_XNOR,
    parameter int         SETTLE_CYC = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             ABORT,
    input  logic             X,
    output logic             A,
    output logic             B,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERR_W-1:0] ERR_CNT
`ifdef GATE_SEQ_OBS_EN
    ,
    output logic [3:0]       OBS
`endif
);

    state_t           r_state;
    logic [1:0]       r_idx;
    logic [ERR_W-1:0] r_err;
    logic             r_a;
    logic             r_b;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;

    logic             w_accept;
    logic             w_next_vec;
    logic             w_load;
    logic             w_count;
    logic             w_expire;
    logic             w_mis;
    logic [ERR_W-1:0] w_err_nxt;
    logic [1:0]       w_idx_nxt;

    // Timer holds SETTLE_CYC-1 so that expiry lands on the last settle cycle
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

    assign w_accept   = (r_state == ST_IDLE) && START && !ABORT;
    assign w_next_vec = (r_state == ST_SAMPLE) && !ABORT
                        && (r_idx != IDX_LAST);
    assign w_load     = w_accept || w_next_vec;
    assign w_count    = (r_state == ST_SETTLE) && !w_expire;

    assign w_mis     = (X != TT[r_idx]);
    assign w_err_nxt = err_step(r_err, w_mis);
    assign w_idx_nxt = r_idx + 2'd1;

    gate_seq_timer u_timer (
        .CLK        (CLK),
        .RST        (RST),
        .i_load     (w_load),
        .i_load_val (SETTLE_LOAD),
        .i_count    (w_count),
        .o_expire   (w_expire)
    );

`ifdef GATE_SEQ_OBS_EN
    logic [3:0] r_obs;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_obs <= 4'd0;
        end else if (w_accept) begin
            r_obs <= 4'd0;
        end else if ((r_state == ST_SAMPLE) && !ABORT) begin
            r_obs[r_idx] <= X;
        end
    end

    assign OBS = r_obs;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_idx   <= 2'd0;
            r_err   <= '0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_idx   <= 2'd0;
                        r_err   <= '0;
                        r_a     <= 1'b0;
                        r_b     <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (ABORT) begin
                        r_a     <= 1'b0;
                        r_b     <= 1'b0;
                        r_pass  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_expire) begin
                        r_state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    // Abort wins over the sample: partial count is kept
                    if (ABORT) begin
                        r_a     <= 1'b0;
                        r_b     <= 1'b0;
                        r_pass  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_err <= w_err_nxt;
                        if (r_idx == IDX_LAST) begin
                            r_a     <= 1'b0;
                            r_b     <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_nxt == '0);
                            r_state <= ST_DONE;
                        end else begin
                            r_idx   <= w_idx_nxt;
                            r_a     <= w_idx_nxt[0];
                            r_b     <= w_idx_nxt[1];
                            r_state <= ST_SETTLE;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign A       = r_a;
    assign B       = r_b;
    assign BUSY    = r_busy;
    assign DONE    = r_done;
    assign PASS    = r_pass;
    assign ERR_CNT = r_err;

endmodule

// File: tb/tb_gate_seq_ctrl.sv
// tb_gate_seq_ctrl: directed scoreboard bench for gate_seq_ctrl (TT=XNOR, SETTLE_CYC=2).
// A behavioural gate drives X from A/B; expected results are queued per run and popped at DONE.
module tb_gate_seq_ctrl;

    localparam logic [3:0] DUT_TT = 4'b1001;
    localparam int         LAT    = 13;

    typedef struct packed {
        logic [2:0] err;
        logic       pass;
        logic [3:0] obs;
    } res_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort_i;
    logic       x;
    logic       a;
    logic       b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_cnt;
`ifdef GATE_SEQ_OBS_EN
    logic [3:0] obs;
`endif

    logic [3:0] gate_tt;
    res_t       exp_res[$];
    logic [1:0] exp_ab[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    assign x = gate_tt[{b, a}];

    always #5 clk = ~clk;

    gate_seq_ctrl #(
        .TT         (DUT_TT),
        .SETTLE_CYC (2)
    ) dut (
        .CLK     (clk),
        .RST     (rst),
        .START   (start),
        .ABORT   (abort_i),
        .X       (x),
        .A       (a),
        .B       (b),
        .BUSY    (busy),
        .DONE    (done),
        .PASS    (pass),
        .ERR_CNT (err_cnt)
`ifdef GATE_SEQ_OBS_EN
        ,
        .OBS     (obs)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, " A"}, 32'(a), 0);
        chk({tag, " B"}, 32'(b), 0);
        chk({tag, " BUSY"}, 32'(busy), 0);
        chk({tag, " DONE"}, 32'(done), 0);
    endtask

    // Full run: START at relative cycle 0, optional stray STARTs at s1/s2
    task automatic run_full(input string tag, input int s1, input int s2);
        res_t       r;
        int         e;
        int         got;
        int         dn;
        logic [1:0] ab;
        e   = 0;
        got = -1;
        for (int i = 0; i < 4; i++) begin
            exp_ab.push_back(2'(i));
            if (gate_tt[i] !== DUT_TT[i]) e++;
        end
        r.err  = 3'((e > 4) ? 4 : e);
        r.pass = (e == 0);
        r.obs  = gate_tt;
        exp_res.push_back(r);

        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            // Vector i is held over cycles 3i+1..3i+3; check the middle one
            if ((c % 3 == 2) && (exp_ab.size() > 0)) begin
                ab = exp_ab.pop_front();
                chk({tag, " {B,A}"}, 32'({b, a}), 32'(ab));
                chk({tag, " BUSY"}, 32'(busy), 1);
            end
            if (done === 1'b1) begin
                got = c;
                break;
            end
            start = (c == s1) || (c == s2);
            tick();
            start = 1'b0;
        end
        exp_ab.delete();
        chk({tag, " latency"}, 32'(got), 32'(LAT));

        r = exp_res.pop_front();
        chk({tag, " ERR_CNT"}, 32'(err_cnt), 32'(r.err));
        chk({tag, " PASS"}, 32'(pass), 32'(r.pass));
`ifdef GATE_SEQ_OBS_EN
        chk({tag, " OBS"}, 32'(obs), 32'(r.obs));
`endif
        tick();
        chk_idle_zero({tag, " post"});

        dn = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done === 1'b1) dn++;
        end
        chk({tag, " extra DONE"}, 32'(dn), 0);
        chk({tag, " hold ERR_CNT"}, 32'(err_cnt), 32'(r.err));
        chk({tag, " hold PASS"}, 32'(pass), 32'(r.pass));
    endtask

    initial begin
        int dn;
        rst     = 1'b1;
        start   = 1'b0;
        abort_i = 1'b0;
        gate_tt = 4'b1001;
        tick();
        tick();
        rst = 1'b0;
        chk_idle_zero("reset");
        chk("reset PASS", 32'(pass), 0);
        chk("reset ERR_CNT", 32'(err_cnt), 0);
`ifdef GATE_SEQ_OBS_EN
        chk("reset OBS", 32'(obs), 0);
`endif

        // Correct XNOR gate
        gate_tt = 4'b1001;
        run_full("xnor", -1, -1);

        // Abort mid-run with an OR gate: idx0 mismatch already counted
        gate_tt = 4'b1110;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 4; k++) tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk_idle_zero("abort");
        chk("abort PASS", 32'(pass), 0);
        chk("abort ERR_CNT", 32'(err_cnt), 1);
        dn = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (done === 1'b1) dn++;
        end
        chk("abort no DONE", 32'(dn), 0);
        gate_tt = 4'b1001;
        run_full("after abort", -1, -1);

        // ABORT with START in IDLE: nothing starts, results held
        start   = 1'b1;
        abort_i = 1'b1;
        tick();
        start   = 1'b0;
        abort_i = 1'b0;
        tick();
        chk("start+abort BUSY", 32'(busy), 0);
        chk("start+abort PASS", 32'(pass), 1);

        // AND gate against XNOR expectation: single mismatch at idx0
        gate_tt = 4'b1000;
        run_full("and", -1, -1);

        // OR gate: every vector wrong, counter must reach 4
        gate_tt = 4'b1110;
        run_full("or sat", -1, -1);

        // Stray STARTs during a run are ignored
        gate_tt = 4'b1001;
        run_full("stray start", 3, 8);

        // Reset mid-run
        gate_tt = 4'b1000;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 3; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle_zero("midrst");
        chk("midrst PASS", 32'(pass), 0);
        chk("midrst ERR_CNT", 32'(err_cnt), 0);
`ifdef GATE_SEQ_OBS_EN
        chk("midrst OBS", 32'(obs), 0);
`endif
        tick();
        gate_tt = 4'b1001;
        run_full("after rst", -1, -1);

        // START during reset is dropped
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        tick();
        chk("rst+start BUSY", 32'(busy), 0);
        tick();
        chk("rst+start BUSY2", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gate_seq_ctrl.md
GATE_SEQ_CTRL -- requirements
Module: gate_seq_ctrl

Interface
REQ-001 Parameter TT, default 4'b1001: expected truth table of the gate under test, indexed by {B,A}; the default is XNOR.
REQ-002 Parameter SETTLE_CYC, default 2: number of settle cycles per vector; the legal range is 1..15.
REQ-003 CLK  input  1  single clock; all logic SHALL be rising-edge triggered.
REQ-004 RST  input  1  reset, synchronous and active-high.
REQ-005 START  input  1  run request; accepted only in IDLE.
REQ-006 ABORT  input  1  cancels a run in progress.
REQ-007 A  output  1  gate input A, driven from a register.
REQ-008 B  output  1  gate input B, driven from a register.
REQ-009 X  input  1  gate output returned from the gate under test.
REQ-010 BUSY  output  1  high while a run is in progress (SETTLE or SAMPLE state).
REQ-011 DONE  output  1  one-cycle pulse when a run completes.
REQ-012 PASS  output  1  1 when the last completed run had zero mismatches.
REQ-013 ERR_CNT  output  3  mismatch count of the current or last run (0..4).
REQ-014 OBS  output  4  observed truth table, indexed by {B,A}; present only when GATE_SEQ_OBS_EN is defined.

Function
REQ-015 FSM states: IDLE, SETTLE, SAMPLE, DONE; the encoding SHALL be one-hot.
REQ-016 IDLE with START=1:
- set vector index idx=0 and ERR_CNT=0;
- drive A=idx[0], B=idx[1];
- clear the settle counter;
- go to SETTLE.
REQ-017 Vector order SHALL be {A,B} = 00, 10, 01, 11 (idx 0..3).
REQ-018 SETTLE SHALL last exactly SETTLE_CYC cycles, then go to SAMPLE; A and B SHALL stay stable throughout.
REQ-019 SAMPLE SHALL last exactly one cycle:
- compare X against TT[idx];
- on mismatch, increment ERR_CNT;
- if idx<3: increment idx, update A/B, go to SETTLE;
- if idx==3: go to DONE.
REQ-020 DONE state: DONE=1 for exactly one cycle; PASS=(final ERR_CNT==0); A=B=0; then go to IDLE.
REQ-021 Latency: with START sampled at cycle 0, DONE SHALL assert at cycle 4*(SETTLE_CYC+1)+1 (cycle 13 for the default).
REQ-022 START SHALL be ignored in SETTLE, SAMPLE and DONE; it SHALL NOT queue.
REQ-023 ABORT in SETTLE or SAMPLE:
- go to IDLE on the next edge;
- A=B=0, PASS=0;
- no DONE pulse;
- ERR_CNT holds its partial value.
REQ-024 ABORT in IDLE or DONE SHALL have no effect.
REQ-025 ABORT and START together in IDLE: ABORT wins and no run starts.
REQ-026 PASS and ERR_CNT SHALL hold their values in IDLE until the next accepted START.
REQ-027 ERR_CNT SHALL saturate at 4 and never wrap.

Reset
REQ-028 RST=1 at any clock edge, including mid-run, SHALL force:
- state=IDLE;
- A=0, B=0, BUSY=0, DONE=0, PASS=0;
- ERR_CNT=0, idx=0, settle counter=0, OBS=0.
REQ-029 START SHALL be ignored during any cycle in which RST=1.

Configuration
REQ-030 Macro GATE_SEQ_OBS_EN defined:
- the OBS port exists;
- in SAMPLE, OBS[idx] SHALL be loaded with X;
- OBS SHALL be cleared when START is accepted.
REQ-031 Macro GATE_SEQ_OBS_EN undefined: the OBS port and its register SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-032 Package gate_seq_pkg SHALL hold:
- state encoding constants;
- vector count (4);
- ERR_CNT width (3);
- default TT for XNOR (4'b1001), AND (4'b1000), OR (4'b1110), XOR (4'b0110).
REQ-033 Sub-module gate_seq_timer SHALL implement the settle down-counter: load, count and expire signals, 4-bit.
REQ-034 The FSM, index register, and compare/count logic SHALL live in gate_seq_ctrl.

Verification
REQ-035 XNOR model, TT=1001, SETTLE_CYC=2, START at cycle 0 -> A/B = 00,10,01,11; DONE at cycle 13; PASS=1; ERR_CNT=0.
REQ-036 AND model with TT=1001 -> ERR_CNT=1 (idx 0); PASS=0; OBS=4'b1000 (macro on).
REQ-037 ABORT at cycle 5 -> BUSY=0 and A=B=0 at cycle 6; no DONE; next START gives a full run with DONE 13 cycles later.
REQ-038 START pulsed at cycles 3 and 8 during a run -> sequence and DONE timing unchanged; exactly one DONE.
REQ-039 RST asserted at cycle 4 -> all outputs reset at cycle 5; START at cycle 6 accepted; DONE at cycle 19.
REQ-040 Build with GATE_SEQ_OBS_EN undefined -> compiles without the OBS port; REQ-035 results unchanged.
